rom_to_ram_writer: RTL and testbench

Write-side companion to the ROM-to-RAM address counter. It owns the `complete` handshake that holds and releases the counter. It samples the address stream the counter produces and delays it to match ROM read latency. It then writes each ROM word into the frame/pattern RAM, and holds `complete` high once the last word has been written.

---
 rtl/rom_to_ram_writer_if.sv | 26 ++
 rtl/rom_to_ram_writer.sv | 118 +++++++++++
 tb/tb_rom_to_ram_writer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rom_to_ram_writer_if.sv
// Handshake and RAM-write bus between the ROM address counter, the ROM and rom_to_ram_writer.
// master = counter/ROM/RAM environment side, slave = the writer.
interface rom_to_ram_writer_if #(
  parameter int unsigned addr_width = 8,
  parameter int unsigned data_width = 32
);
   logic                  start;
   logic [addr_width-1:0] src_addr;
   logic [data_width-1:0] rom_data;
   logic                  complete;
   logic                  busy;
   logic                  ram_we;
   logic [addr_width-1:0] ram_addr;
   logic [data_width-1:0] ram_wdata;
   logic [data_width-1:0] checksum;

   modport master (
      output start, src_addr, rom_data,
      input  complete, busy, ram_we, ram_addr, ram_wdata, checksum
   );

   modport slave (
      input  start, src_addr, rom_data,
      output complete, busy, ram_we, ram_addr, ram_wdata, checksum
   );
endinterface

// File: rtl/rom_to_ram_writer.sv
// Write side of the ROM-to-RAM loader: owns `complete`, delays the counter address to match ROM
// latency and writes each word once. Optional running word sum enabled by CHECKSUM_EN.
module rom_to_ram_writer #(
  parameter int unsigned addr_width  = 8,
  parameter int unsigned data_width  = 32,
  parameter int unsigned ROM_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  rom_to_ram_writer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

   localparam logic [addr_width-1:0] LastAddr = '1;

   state_e                state_q, state_d;
   logic                  issue_en_q, issue_en_d;
   logic                  complete_q, busy_q;
   logic                  ram_we_q;
   logic [addr_width-1:0] ram_addr_q;
   logic [data_width-1:0] ram_wdata_q;
   logic [addr_width-1:0] pipe_addr_q [ROM_LATENCY];
   logic [ROM_LATENCY-1:0] pipe_vld_q;
   logic                  last_write;
   logic                  load_req;

   assign last_write = ram_we_q && (ram_addr_q == LastAddr);
   assign load_req   = (state_q != StFill) && bus.start;

   always_comb begin
      state_d    = state_q;
      issue_en_d = issue_en_q;
      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d    = StFill;
               issue_en_d = 1'b1;
            end
         end
         StFill: begin
            // Stop issuing once the top address is captured so the counter wrap never rewrites 0.
            if (issue_en_q && (bus.src_addr == LastAddr)) issue_en_d = 1'b0;
            if (last_write) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         issue_en_q <= 1'b0;
         complete_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         issue_en_q <= issue_en_d;
         complete_q <= (state_d != StFill);
         busy_q     <= (state_d == StFill);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_vld_q <= '0;
         for (int i = 0; i < int'(ROM_LATENCY); i++) pipe_addr_q[i] <= '0;
      end else begin
         pipe_addr_q[0] <= bus.src_addr;
         pipe_vld_q[0]  <= (state_q == StFill) && issue_en_q;
         for (int i = 1; i < int'(ROM_LATENCY); i++) begin
            pipe_addr_q[i] <= pipe_addr_q[i-1];
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         ram_we_q <= pipe_vld_q[ROM_LATENCY-1];
         if (pipe_vld_q[ROM_LATENCY-1]) begin
            ram_addr_q  <= pipe_addr_q[ROM_LATENCY-1];
            ram_wdata_q <= bus.rom_data;
         end
      end
   end

`ifdef CHECKSUM_EN
   logic [data_width-1:0] checksum_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         checksum_q <= '0;
      end else if (load_req) begin
         checksum_q <= '0;
      end else if (pipe_vld_q[ROM_LATENCY-1]) begin
         checksum_q <= checksum_q + bus.rom_data;
      end
   end

   assign bus.checksum = checksum_q;
`else
   logic unused_load_req;
   assign unused_load_req = load_req;
   assign bus.checksum    = '0;
`endif

   assign bus.complete  = complete_q;
   assign bus.busy      = busy_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_rom_to_ram_writer.sv
// Bench for rom_to_ram_writer: two instances (ROM latency 1 and 3) fed by a counter model and
// a ROM model holding rom[i] = 3i+1; table-driven cycle checks plus write-stream scoreboarding.
module tb_rom_to_ram_writer;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int NW = 16;
   localparam int LOGN = 30;
`ifdef CHECKSUM_EN
   localparam logic [DW-1:0] ExpCs = 32'd376;
`else
   localparam logic [DW-1:0] ExpCs = 32'd0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;

   always #5 clk = ~clk;

   rom_to_ram_writer_if #(.addr_width(AW), .data_width(DW)) bus1 ();
   rom_to_ram_writer_if #(.addr_width(AW), .data_width(DW)) bus3 ();

   rom_to_ram_writer #(.addr_width(AW), .data_width(DW), .ROM_LATENCY(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   rom_to_ram_writer #(.addr_width(AW), .data_width(DW), .ROM_LATENCY(3)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   // Counter models: held at 0 while complete, otherwise increment every cycle.
   logic [AW-1:0] cnt1, cnt3;
   logic [AW-1:0] rd1;
   logic [AW-1:0] rd3 [3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt1 <= '0;
         cnt3 <= '0;
      end else begin
         cnt1 <= bus1.complete ? '0 : cnt1 + 1'b1;
         cnt3 <= bus3.complete ? '0 : cnt3 + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      rd1    <= cnt1;
      rd3[0] <= cnt3;
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end

   assign bus1.start    = start;
   assign bus3.start    = start;
   assign bus1.src_addr = cnt1;
   assign bus3.src_addr = cnt3;
   assign bus1.rom_data = {28'd0, rd1} * 32'd3 + 32'd1;
   assign bus3.rom_data = {28'd0, rd3[2]} * 32'd3 + 32'd1;

   int checks = 0;
   int failures = 0;

   logic          lg_cpl  [2][LOGN];
   logic          lg_busy [2][LOGN];
   logic          lg_we   [2][LOGN];
   logic [AW-1:0] lg_addr [2][LOGN];
   logic [DW-1:0] lg_wd   [2][LOGN];
   logic [DW-1:0] lg_cs   [2][LOGN];

   typedef struct {
      int            dut;
      int            cyc;
      logic          cpl;
      logic          busy;
      logic          we;
      logic          chk;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic sample(input int c);
      lg_cpl[0][c]  = bus1.complete;
      lg_busy[0][c] = bus1.busy;
      lg_we[0][c]   = bus1.ram_we;
      lg_addr[0][c] = bus1.ram_addr;
      lg_wd[0][c]   = bus1.ram_wdata;
      lg_cs[0][c]   = bus1.checksum;
      lg_cpl[1][c]  = bus3.complete;
      lg_busy[1][c] = bus3.busy;
      lg_we[1][c]   = bus3.ram_we;
      lg_addr[1][c] = bus3.ram_addr;
      lg_wd[1][c]   = bus3.ram_wdata;
      lg_cs[1][c]   = bus3.checksum;
   endtask

   // Pulse start, then log cycles F0..F(LOGN-1); optionally pulse start again during F5.
   task automatic run_load(input bit poke);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < LOGN; c++) begin
         if (c > 0) @(negedge clk);
         sample(c);
         if (poke && c == 5) start = 1'b1;
         if (poke && c == 6) start = 1'b0;
      end
   endtask

   task automatic score(input int d, input int lat, input string tag);
      int nw = 0;
      int bad = 0;
      int low = 0;
      int first = -1;
      int last = -1;
      for (int c = 0; c < LOGN; c++) begin
         if (!lg_cpl[d][c]) low++;
         if (lg_we[d][c]) begin
            if (lg_addr[d][c] != AW'(nw) || lg_wd[d][c] != 32'(3 * nw + 1)) bad++;
            if (first < 0) first = c;
            last = c;
            nw++;
         end
      end
      check({tag, "_writes"}, 64'(nw), 64'(NW));
      check({tag, "_order"}, 64'(bad), 64'd0);
      check({tag, "_first"}, 64'(first), 64'(lat + 1));
      check({tag, "_last"}, 64'(last), 64'(NW + lat));
      check({tag, "_low"}, 64'(low), 64'(NW + lat + 1));
      check({tag, "_cs0"}, 64'(lg_cs[d][0]), 64'd0);
      check({tag, "_csend"}, 64'(lg_cs[d][LOGN-1]), 64'(ExpCs));
   endtask

   task automatic apply_table(input string tag);
      for (int i = 0; i < 11; i++) begin
         int d = tbl[i].dut;
         int c = tbl[i].cyc;
         check($sformatf("%s_v%0d_cpl", tag, i), 64'(lg_cpl[d][c]), 64'(tbl[i].cpl));
         check($sformatf("%s_v%0d_busy", tag, i), 64'(lg_busy[d][c]), 64'(tbl[i].busy));
         check($sformatf("%s_v%0d_we", tag, i), 64'(lg_we[d][c]), 64'(tbl[i].we));
         if (tbl[i].chk) begin
            check($sformatf("%s_v%0d_addr", tag, i), 64'(lg_addr[d][c]), 64'(tbl[i].addr));
            check($sformatf("%s_v%0d_wd", tag, i), 64'(lg_wd[d][c]), 64'(tbl[i].wd));
         end
      end
   endtask

   initial begin
      //        dut cyc cpl  busy  we    chk   addr   wdata
      tbl = '{
         '{0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  32'd0},
         '{0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  32'd0},
         '{0,  2, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  32'd1},
         '{0,  3, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1,  32'd4},
         '{0, 17, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 32'd46},
         '{0, 18, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  32'd0},
         '{1,  3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  32'd0},
         '{1,  4, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  32'd1},
         '{1, 18, 1'b0, 1'b1, 1'b1, 1'b1, 4'd14, 32'd43},
         '{1, 19, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 32'd46},
         '{1, 20, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  32'd0}
      };

      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Idle after reset: complete high, nothing written, counters parked at 0.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("idle%0d_flags", c),
               64'({bus1.complete, bus1.busy, bus1.ram_we, bus3.complete, bus3.busy, bus3.ram_we}),
               64'(6'b100100));
         check($sformatf("idle%0d_cnt", c), 64'({cnt1, cnt3}), 64'd0);
      end

      run_load(1'b0);
      apply_table("load");
      score(0, 1, "load_l1");
      score(1, 3, "load_l3");

      // Reload from DONE with a stray start in F5; must match the undisturbed run.
      run_load(1'b1);
      apply_table("poke");
      score(0, 1, "poke_l1");
      score(1, 3, "poke_l3");

      // Asynchronous reset in F7, while the latency-1 instance is mid-write.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_rst_we1", 64'(bus1.ram_we), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_we1", 64'(bus1.ram_we), 64'd0);
      check("rst_cpl", 64'({bus1.complete, bus3.complete}), 64'(2'b11));
      check("rst_busy", 64'({bus1.busy, bus3.busy}), 64'(2'b00));
      check("rst_cs", 64'(bus1.checksum), 64'd0);
      @(negedge clk) reset = 1'b0;
      run_load(1'b0);
      score(0, 1, "after_rst_l1");
      score(1, 3, "after_rst_l3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
